multi_nco: RTL and testbench

//  Multi-channel numerically controlled oscillator. Each channel has a phase

---
 rtl/multi_nco_pkg.sv | 27 ++
 rtl/quad_sine_lut.sv | 27 ++
 rtl/multi_nco.sv | 177 +++++++++++++++++
 tb/tb_multi_nco.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_nco_pkg.sv
// rtl/multi_nco_pkg.sv - config selectors, amplitude unity and quarter-wave LUT contents rule
package multi_nco_pkg;

  typedef enum logic [1:0] {
    CFG_FTW  = 2'd0,
    CFG_OFF  = 2'd1,
    CFG_AMP  = 2'd2,
    CFG_PRST = 2'd3
  } cfg_sel_e;

  localparam real PI = 3.14159265358979323846;

  // Amplitude code that passes samples through unscaled.
  function automatic int amp_unity(input int dw);
    return 1 << (dw - 1);
  endfunction

  // Half-step sample points make the quarter table mirror exactly and keep every entry nonzero.
  function automatic int quarter_lut_entry(input int k, input int aw, input int dw);
    real ang;
    real mag;
    ang = 2.0 * PI * (real'(k) + 0.5) / (2.0 ** real'(aw + 2));
    mag = real'(amp_unity(dw) - 1) * $sin(ang);
    return $rtoi(mag + 0.5);
  endfunction

endpackage

// File: rtl/quad_sine_lut.sv
// rtl/quad_sine_lut.sv - registered-read quarter-wave sine ROM
module quad_sine_lut
  import multi_nco_pkg::*;
#(
  parameter int AW = 14,
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_data
);

  logic [DW-1:0] rom [2**AW];
  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;

  for (genvar k = 0; k < 2**AW; k++) begin : g_rom
    assign rom[k] = DW'(quarter_lut_entry(k, AW, DW));
  end

  always_comb data_d = rom[i_addr];

  always_ff @(posedge i_clk) data_q <= data_d;

  assign o_data = data_q;

endmodule

// File: rtl/multi_nco.sv
// rtl/multi_nco.sv - multi-channel NCO sharing one quarter-wave LUT round-robin
module multi_nco
  import multi_nco_pkg::*;
#(
  parameter int  PHASE_W = 32,
  parameter int  ADDR_W  = 16,
  parameter int  DATA_W  = 16,
  parameter int  NUM_CH  = 4,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic               i_cfg_we,
  input  logic [CH_W-1:0]    i_cfg_ch,
  input  logic [1:0]         i_cfg_sel,
  input  logic [PHASE_W-1:0] i_cfg_data,
  output logic               o_valid,
  output logic [CH_W-1:0]    o_ch,
  output logic [DATA_W-1:0]  o_data
);

  localparam int                LAW       = ADDR_W - 2;
  localparam logic [DATA_W-1:0] AMP_UNITY = DATA_W'(amp_unity(DATA_W));
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  logic [PHASE_W-1:0] acc_d [NUM_CH];
  logic [PHASE_W-1:0] acc_q [NUM_CH];
  logic [PHASE_W-1:0] ftw_d [NUM_CH];
  logic [PHASE_W-1:0] ftw_q [NUM_CH];
  logic [PHASE_W-1:0] off_d [NUM_CH];
  logic [PHASE_W-1:0] off_q [NUM_CH];
  logic [DATA_W-1:0]  amp_d [NUM_CH];
  logic [DATA_W-1:0]  amp_q [NUM_CH];
  logic [DATA_W-1:0]  amp_wr;
  logic [CH_W-1:0]    slot_d, slot_q;

  logic               p0_valid_d, p0_valid_q;
  logic [CH_W-1:0]    p0_ch_d, p0_ch_q;
  logic [ADDR_W-1:0]  p0_phase_d, p0_phase_q;
  logic [DATA_W-1:0]  p0_amp_d, p0_amp_q;

  logic               p1_valid_d, p1_valid_q;
  logic [CH_W-1:0]    p1_ch_d, p1_ch_q;
  logic               p1_neg_d, p1_neg_q;
  logic [LAW-1:0]     p1_addr_d, p1_addr_q;
  logic [DATA_W-1:0]  p1_amp_d, p1_amp_q;

  logic               p2_valid_d, p2_valid_q;
  logic [CH_W-1:0]    p2_ch_d, p2_ch_q;
  logic               p2_neg_d, p2_neg_q;
  logic [DATA_W-1:0]  p2_amp_d, p2_amp_q;
  logic [DATA_W-1:0]  lut_data;

  logic                     p3_valid_d, p3_valid_q;
  logic [CH_W-1:0]          p3_ch_d, p3_ch_q;
  logic signed [DATA_W-1:0] p3_s_d, p3_s_q;
  logic [DATA_W-1:0]        p3_amp_d, p3_amp_q;

  logic                     out_valid_d, out_valid_q;
  logic [CH_W-1:0]          out_ch_d, out_ch_q;
  logic [DATA_W-1:0]        out_data_d, out_data_q;
  logic signed [2*DATA_W:0] prod;

  // Slot issue reads pre-write config; phase reset is applied last so it wins over the accumulate.
  always_comb begin
    acc_d      = acc_q;
    ftw_d      = ftw_q;
    off_d      = off_q;
    amp_d      = amp_q;
    slot_d     = slot_q;
    p0_valid_d = 1'b0;
    p0_ch_d    = p0_ch_q;
    p0_phase_d = p0_phase_q;
    p0_amp_d   = p0_amp_q;
    amp_wr     = (i_cfg_data[DATA_W-1:0] > AMP_UNITY) ? AMP_UNITY : i_cfg_data[DATA_W-1:0];
    if (i_run) begin
      p0_valid_d    = 1'b1;
      p0_ch_d       = slot_q;
      p0_phase_d    = ADDR_W'((acc_q[slot_q] + off_q[slot_q]) >> (PHASE_W - ADDR_W));
      p0_amp_d      = amp_q[slot_q];
      acc_d[slot_q] = acc_q[slot_q] + ftw_q[slot_q];
      slot_d        = (slot_q == LAST_CH) ? '0 : slot_q + 1'b1;
    end
    if (i_cfg_we && (int'(i_cfg_ch) < NUM_CH)) begin
      case (cfg_sel_e'(i_cfg_sel))
        CFG_FTW:  ftw_d[i_cfg_ch] = i_cfg_data;
        CFG_OFF:  off_d[i_cfg_ch] = i_cfg_data;
        CFG_AMP:  amp_d[i_cfg_ch] = amp_wr;
        CFG_PRST: acc_d[i_cfg_ch] = '0;
      endcase
    end
  end

  always_comb begin
    p1_valid_d  = p0_valid_q;
    p1_ch_d     = p0_ch_q;
    p1_amp_d    = p0_amp_q;
    p1_neg_d    = p0_phase_q[ADDR_W-1];
    p1_addr_d   = p0_phase_q[ADDR_W-2] ? ~p0_phase_q[LAW-1:0] : p0_phase_q[LAW-1:0];
    p2_valid_d  = p1_valid_q;
    p2_ch_d     = p1_ch_q;
    p2_neg_d    = p1_neg_q;
    p2_amp_d    = p1_amp_q;
    p3_valid_d  = p2_valid_q;
    p3_ch_d     = p2_ch_q;
    p3_amp_d    = p2_amp_q;
    p3_s_d      = p2_neg_q ? -$signed(lut_data) : $signed(lut_data);
    prod        = p3_s_q * $signed({1'b0, p3_amp_q});
    out_valid_d = p3_valid_q;
    out_ch_d    = p3_ch_q;
    out_data_d  = DATA_W'(prod >>> (DATA_W - 1));
  end

  quad_sine_lut #(
    .AW (LAW),
    .DW (DATA_W)
  ) u_lut (
    .i_clk  (i_clk),
    .i_addr (p1_addr_q),
    .o_data (lut_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        ftw_q[c] <= '0;
        off_q[c] <= '0;
        amp_q[c] <= AMP_UNITY;
      end
      slot_q      <= '0;
      p0_valid_q  <= 1'b0;
      p1_valid_q  <= 1'b0;
      p2_valid_q  <= 1'b0;
      p3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      ftw_q       <= ftw_d;
      off_q       <= off_d;
      amp_q       <= amp_d;
      slot_q      <= slot_d;
      p0_valid_q  <= p0_valid_d;
      p1_valid_q  <= p1_valid_d;
      p2_valid_q  <= p2_valid_d;
      p3_valid_q  <= p3_valid_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

  // Datapath payload is qualified by the valids, so it needs no reset.
  always_ff @(posedge i_clk) begin
    p0_ch_q    <= p0_ch_d;
    p0_phase_q <= p0_phase_d;
    p0_amp_q   <= p0_amp_d;
    p1_ch_q    <= p1_ch_d;
    p1_neg_q   <= p1_neg_d;
    p1_addr_q  <= p1_addr_d;
    p1_amp_q   <= p1_amp_d;
    p2_ch_q    <= p2_ch_d;
    p2_neg_q   <= p2_neg_d;
    p2_amp_q   <= p2_amp_d;
    p3_ch_q    <= p3_ch_d;
    p3_s_q     <= p3_s_d;
    p3_amp_q   <= p3_amp_d;
  end

  assign o_valid = out_valid_q;
  assign o_ch    = out_ch_q;
  assign o_data  = out_data_q;

endmodule

// File: tb/tb_multi_nco.sv
// tb/tb_multi_nco.sv - scoreboard bench for multi_nco, 4-channel and 3-channel builds
module tb_multi_nco;

  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int ch;
    int data;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        v4, v3;
  logic [1:0]  ch4, ch3;
  logic [15:0] d4, d3;

  multi_nco u_dut4 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_run      (run),
    .i_cfg_we   (cfg_we),
    .i_cfg_ch   (cfg_ch),
    .i_cfg_sel  (cfg_sel),
    .i_cfg_data (cfg_data),
    .o_valid    (v4),
    .o_ch       (ch4),
    .o_data     (d4)
  );

  multi_nco #(.NUM_CH(3)) u_dut3 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_run      (run),
    .i_cfg_we   (cfg_we),
    .i_cfg_ch   (cfg_ch),
    .i_cfg_sel  (cfg_sel),
    .i_cfg_data (cfg_data),
    .o_valid    (v3),
    .o_ch       (ch3),
    .o_data     (d3)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          nch [2] = '{4, 3};
  logic [31:0] m_acc [2][4];
  logic [31:0] m_ftw [2][4];
  logic [31:0] m_off [2][4];
  int          m_amp [2][4];
  int          m_slot [2];
  exp_t        sb4[$];
  exp_t        sb3[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Full-circle sine evaluated directly, then scaled with floor division.
  function automatic int exp_sample(input logic [31:0] phase, input int amp);
    int     p;
    int     r;
    real    v;
    longint prod;
    p    = int'(phase[31:16]);
    v    = 32767.0 * $sin(2.0 * PI * (real'(p) + 0.5) / 65536.0);
    r    = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    prod = longint'(r) * longint'(amp);
    return int'(prod >>> 15);
  endfunction

  task automatic model_step();
    logic [31:0] ph;
    exp_t        e;
    int          s;
    int          a;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int c = 0; c < 4; c++) begin
          m_acc[i][c] = '0;
          m_ftw[i][c] = '0;
          m_off[i][c] = '0;
          m_amp[i][c] = 32768;
        end
        m_slot[i] = 0;
        if (i == 0) sb4.delete(); else sb3.delete();
      end else begin
        if (run) begin
          s      = m_slot[i];
          ph     = m_acc[i][s] + m_off[i][s];
          e.ch   = s;
          e.data = exp_sample(ph, m_amp[i][s]);
          e.cyc  = cyc;
          if (i == 0) sb4.push_back(e); else sb3.push_back(e);
          m_acc[i][s] = m_acc[i][s] + m_ftw[i][s];
          m_slot[i]   = (s == nch[i] - 1) ? 0 : s + 1;
        end
        if (cfg_we && int'(cfg_ch) < nch[i]) begin
          case (cfg_sel)
            2'd0: m_ftw[i][cfg_ch] = cfg_data;
            2'd1: m_off[i][cfg_ch] = cfg_data;
            2'd2: begin
              a = int'(cfg_data[15:0]);
              m_amp[i][cfg_ch] = (a > 32768) ? 32768 : a;
            end
            default: m_acc[i][cfg_ch] = '0;
          endcase
        end
      end
    end
  endtask

  task automatic check_out(input int i, input logic v, input logic [1:0] ch, input logic [15:0] d);
    exp_t  e;
    int    have;
    string sfx;
    sfx  = (i == 0) ? "4ch" : "3ch";
    have = (i == 0) ? sb4.size() : sb3.size();
    if (v) begin
      check({"valid_expected_", sfx}, longint'(have > 0), 1);
      if (have > 0) begin
        if (i == 0) e = sb4.pop_front(); else e = sb3.pop_front();
        check({"ch_", sfx}, longint'(ch), e.ch);
        check({"data_", sfx}, longint'($signed(d)), e.data);
        check({"latency_", sfx}, cyc, e.cyc + 4);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_out(0, v4, ch4, d4);
    check_out(1, v3, ch3, d3);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] data);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_sel  = sel;
    cfg_data = data;
    cycle();
    cfg_we   = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    run = 1'b0;
    repeat (6) cycle();
    check({tag, "_queue_4ch"}, sb4.size(), 0);
    check({tag, "_queue_3ch"}, sb3.size(), 0);
    check({tag, "_valid_4ch"}, v4, 0);
    check({tag, "_valid_3ch"}, v3, 0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    repeat (3) cycle();
    check("rst_valid_4ch", v4, 0);
    check("rst_data_4ch", d4, 0);
    check("rst_ch_4ch", ch4, 0);
    check("rst_valid_3ch", v3, 0);
    check("rst_data_3ch", d3, 0);
    rst = 1'b0;

    run = 1'b1;
    repeat (12) cycle();
    drain_check("ftw0");

    cfg(2'd0, 2'd0, 32'h4000_0000);
    run = 1'b1;
    repeat (16) cycle();
    cfg(2'd0, 2'd2, 32'h0000_4000);
    repeat (16) cycle();
    cfg(2'd0, 2'd2, 32'h0000_FFFF);
    repeat (16) cycle();

    cfg(2'd0, 2'd0, 32'h0);
    cfg(2'd0, 2'd3, 32'h0);
    cfg(2'd1, 2'd1, 32'h4000_0000);
    cfg(2'd2, 2'd1, 32'h8000_0000);
    cfg(2'd3, 2'd1, 32'hC000_0000);
    repeat (16) cycle();

    cfg(2'd0, 2'd0, 32'h1234_5678);
    repeat (5) cycle();
    for (int k = 0; k < 8 && m_slot[0] != 0; k++) cycle();
    cfg(2'd0, 2'd3, 32'h0);
    repeat (12) cycle();

    for (int k = 0; k < 80; k++) begin
      run      = ($urandom_range(0, 3) != 0);
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_ch   = 2'($urandom);
      cfg_sel  = 2'($urandom);
      cfg_data = $urandom;
      cycle();
    end
    cfg_we = 1'b0;

    run = 1'b1;
    repeat (7) cycle();
    drain_check("stop");
    run = 1'b1;
    repeat (9) cycle();
    rst = 1'b1;
    cycle();
    check("midrst_valid_4ch", v4, 0);
    check("midrst_valid_3ch", v3, 0);
    rst = 1'b0;
    cfg(2'd0, 2'd0, 32'h4000_0000);
    cfg(2'd1, 2'd0, 32'h2000_0000);
    repeat (12) cycle();
    drain_check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
